// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-loader byte-stream framing.
// Holds the loader FSM state encoding and the header length. The future
// memory-dump reader uses the same framing.
package prog_loader_pkg;

  // Loader FSM states. Plain 2-bit constants keep the encoding fixed for
  // legacy tools and waveform viewers.
  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  // Number of bytes in the little-endian word-count header. This also
  // equals the number of bytes in one data word.
  localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/prog_loader_le_word_asm.sv
// Little-endian 8-to-32 word assembler.
// Bytes arrive least-significant first. o_word_valid pulses combinationally
// in the same cycle the fourth byte is accepted, and o_word then shows the
// completed word.
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   i_clear      synchronous clear of the position counter and partial word
//   i_valid      i_byte is accepted this cycle
//   i_byte       stream byte
//   o_word       assembled word (valid while o_word_valid is high)
//   o_word_valid the fourth byte of a word is being accepted
module prog_loader_le_word_asm
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  localparam logic [1:0] LastPos = 2'(HDR_BYTES - 1);

  logic [1:0]  r_pos;
  logic [31:0] r_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_pos  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_valid) begin
      // Shift right so that the first byte ends up in bits [7:0].
      r_word <= {i_byte, r_word[31:8]};
      r_pos  <= r_pos + 2'd1;
    end
  end

  always_comb begin
    o_word       = {i_byte, r_word[31:8]};
    o_word_valid = i_valid && (r_pos == LastPos);
  end

endmodule

// File: rtl/prog_loader.sv
// Program-image loader. Drives the CPU top level's external memory-write
// port.
// It takes a byte stream made of a 4-byte LE word count N followed by N LE
// words. It writes each word at incrementing word addresses from BASE_ADDR.
// The CPU is held in reset until the image is complete.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   in_data        stream byte
//   in_valid       in_data valid
//   in_ready       loader accepts a byte this cycle
//   Ext_MemWrite   single-cycle write strobe
//   Ext_WriteData  assembled word
//   Ext_DataAdr    byte address of the word
//   cpu_reset      active-high CPU reset
//   done           image fully written
//   error          header exceeded MAX_WORDS (sticky until reset)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [CNT_W-1:0] r_remaining;
  logic             r_error;

  logic             w_accept;
  logic             w_asm_clear;
  logic [31:0]      w_word;
  logic             w_word_valid;

  // Gating with reset_n keeps in_ready low while reset is held, even though
  // the state register already sits in HDR.
  always_comb begin
    in_ready    = reset_n && ((r_state == ST_HDR) || (r_state == ST_DATA));
    w_accept    = in_valid && in_ready;
    w_asm_clear = (r_state == ST_RUN);
  end

  prog_loader_le_word_asm u_le_word_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_asm_clear),
    .i_valid      (w_accept),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_HDR;
      r_addr      <= BASE_ADDR;
      r_wdata     <= 32'd0;
      r_remaining <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_word_valid) begin
            if (w_word == 32'd0) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DATA;
              if (w_word > 32'(MAX_WORDS)) begin
                // Clamp oversized images. Surplus bytes stay unconsumed.
                r_remaining <= CNT_W'(MAX_WORDS);
                r_error     <= 1'b1;
              end else begin
                r_remaining <= CNT_W'(w_word);
              end
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            r_wdata <= w_word;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_addr      <= r_addr + 32'd4;
          r_remaining <= r_remaining - CNT_W'(1);
          r_state     <= (r_remaining == CNT_W'(1)) ? ST_RUN : ST_DATA;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Ext_MemWrite  = (r_state == ST_WRITE);
    Ext_WriteData = r_wdata;
    Ext_DataAdr   = r_addr;
    cpu_reset     = (r_state != ST_RUN);
    done          = (r_state == ST_RUN);
    error         = r_error;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: dut_a uses default parameters and
// dut_b uses MAX_WORDS=2 for the clamp case.
module tb_prog_loader;

  logic        clk;
  logic        rst_a_n, rst_b_n;
  logic [7:0]  a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_rdy, b_rdy, a_mw, b_mw;
  logic [31:0] a_wd, b_wd, a_adr, b_adr;
  logic        a_cpr, b_cpr, a_done, b_done, a_err, b_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_a    = 0;
  int cnt_b    = 0;
  logic [63:0] q_a[$];
  logic [63:0] q_b[$];
  int          wcyc_a[$];

  prog_loader dut_a (
    .clk(clk), .reset_n(rst_a_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_rdy), .Ext_MemWrite(a_mw), .Ext_WriteData(a_wd),
    .Ext_DataAdr(a_adr), .cpu_reset(a_cpr), .done(a_done), .error(a_err)
  );

  prog_loader #(.MAX_WORDS(2)) dut_b (
    .clk(clk), .reset_n(rst_b_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_rdy), .Ext_MemWrite(b_mw), .Ext_WriteData(b_wd),
    .Ext_DataAdr(b_adr), .cpu_reset(b_cpr), .done(b_done), .error(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitors: pop the expected write from the queue on every strobe.
  always @(negedge clk) begin
    if (rst_a_n && a_mw) begin
      cnt_a++;
      wcyc_a.push_back(cyc);
      chk("a_ready_in_write", 32'(a_rdy), 32'd0);
      chk("a_cpu_reset_in_write", 32'(a_cpr), 32'd1);
      if (q_a.size() == 0) begin
        chk("a_spurious_strobe", a_adr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = q_a.pop_front();
        chk("a_addr", a_adr, e[63:32]);
        chk("a_data", a_wd, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n && b_mw) begin
      cnt_b++;
      chk("b_ready_in_write", 32'(b_rdy), 32'd0);
      if (q_b.size() == 0) begin
        chk("b_spurious_strobe", b_adr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = q_b.pop_front();
        chk("b_addr", b_adr, e[63:32]);
        chk("b_data", b_wd, e[31:0]);
      end
    end
  end

  // Issue one byte; returns at posedge+1 after the byte transfers.
  task automatic send_byte(input int sel, input logic [7:0] b);
    int budget;
    logic rdy;
    budget = 0;
    if (sel == 0) begin a_data = b; a_valid = 1'b1; end
    else begin b_data = b; b_valid = 1'b1; end
    @(negedge clk);
    rdy = (sel == 0) ? a_rdy : b_rdy;
    while (!rdy && budget < 100) begin
      @(negedge clk);
      rdy = (sel == 0) ? a_rdy : b_rdy;
      budget++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // gap_base < 0 means back-to-back bytes; otherwise 0..7 idle cycles per byte.
  task automatic send_word(input int sel, input logic [31:0] w, input int gap_base);
    for (int i = 0; i < 4; i++) begin
      if (gap_base >= 0) begin
        repeat ((gap_base + i * 3) % 8) begin @(posedge clk); #1; end
      end
      send_byte(sel, w[8*i +: 8]);
    end
  endtask

  task automatic reset_a();
    @(posedge clk); #3;
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    cnt_a = 0;
    wcyc_a.delete();
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_data = 8'h00; b_data = 8'h00; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values.
    chk("rst_mw", 32'(a_mw), 32'd0);
    chk("rst_wd", a_wd, 32'd0);
    chk("rst_adr", a_adr, 32'd0);
    chk("rst_cpu_reset", 32'(a_cpr), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_error", 32'(a_err), 32'd0);
    chk("rst_ready", 32'(a_rdy), 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(a_rdy), 32'd1);

    // Single word, DEADBEEF.
    send_word(0, 32'd1, -1);
    q_a.push_back({32'h0, 32'hDEADBEEF});
    send_word(0, 32'hDEADBEEF, -1);
    chk("t1_strobe_latency", 32'(a_mw), 32'd1);
    @(posedge clk); #1;
    chk("t1_cpu_reset", 32'(a_cpr), 32'd0);
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_count", 32'(cnt_a), 32'd1);

    // Three words back to back, writes five cycles apart.
    reset_a();
    send_word(0, 32'd3, -1);
    q_a.push_back({32'h0, 32'h11111111});
    send_word(0, 32'h11111111, -1);
    q_a.push_back({32'h4, 32'h22222222});
    send_word(0, 32'h22222222, -1);
    q_a.push_back({32'h8, 32'h33333333});
    send_word(0, 32'h33333333, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_count", 32'(cnt_a), 32'd3);
    chk("t2_done", 32'(a_done), 32'd1);
    if (wcyc_a.size() == 3) begin
      chk("t2_spacing01", 32'(wcyc_a[1] - wcyc_a[0]), 32'd5);
      chk("t2_spacing12", 32'(wcyc_a[2] - wcyc_a[1]), 32'd5);
    end

    // Two words with idle gaps, including mid-word.
    reset_a();
    send_word(0, 32'd2, 2);
    q_a.push_back({32'h0, 32'hA1B2C3D4});
    send_word(0, 32'hA1B2C3D4, 5);
    q_a.push_back({32'h4, 32'h0F1E2D3C});
    send_word(0, 32'h0F1E2D3C, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_count", 32'(cnt_a), 32'd2);
    chk("t3_done", 32'(a_done), 32'd1);
    chk("t3_next_adr", a_adr, 32'h8);

    // Empty image.
    reset_a();
    send_word(0, 32'd0, -1);
    chk("t4_done", 32'(a_done), 32'd1);
    chk("t4_cpu_reset", 32'(a_cpr), 32'd0);
    chk("t4_ready", 32'(a_rdy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_count", 32'(cnt_a), 32'd0);

    // Clamp on dut_b: N=5 with MAX_WORDS=2.
    send_word(1, 32'd5, -1);
    chk("t5_error", 32'(b_err), 32'd1);
    q_b.push_back({32'h0, 32'h01020304});
    send_word(1, 32'h01020304, -1);
    q_b.push_back({32'h4, 32'h05060708});
    send_word(1, 32'h05060708, -1);
    @(posedge clk); #1;
    chk("t5_done", 32'(b_done), 32'd1);
    chk("t5_cpu_reset", 32'(b_cpr), 32'd0);
    b_valid = 1'b1;
    b_data  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("t5_extra_ready", 32'(b_rdy), 32'd0);
    end
    b_valid = 1'b0;
    chk("t5_count", 32'(cnt_b), 32'd2);
    chk("t5_error_sticky", 32'(b_err), 32'd1);

    // Asynchronous reset in the middle of word 2.
    reset_a();
    send_word(0, 32'd2, -1);
    q_a.push_back({32'h0, 32'h12345678});
    send_word(0, 32'h12345678, -1);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    #3;
    rst_a_n = 1'b0;
    #1;
    chk("t6_mw", 32'(a_mw), 32'd0);
    chk("t6_wd", a_wd, 32'd0);
    chk("t6_adr", a_adr, 32'd0);
    chk("t6_cpu_reset", 32'(a_cpr), 32'd1);
    chk("t6_done", 32'(a_done), 32'd0);
    chk("t6_ready", 32'(a_rdy), 32'd0);
    @(posedge clk); #1;
    rst_a_n = 1'b1;
    send_word(0, 32'd1, -1);
    q_a.push_back({32'h0, 32'hCAFEF00D});
    send_word(0, 32'hCAFEF00D, -1);
    @(posedge clk); #1;
    chk("t6_done_reload", 32'(a_done), 32'd1);
    chk("t6_count", 32'(cnt_a), 32'd2);

    repeat (2) @(posedge clk);
    chk("q_a_empty", 32'(q_a.size()), 32'd0);
    chk("q_b_empty", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Initiator side of the CPU top-level's external memory-write port (Ext_MemWrite / Ext_WriteData / Ext_DataAdr), which the top level honours only while its active-high CPU reset is asserted.
- Accepts a byte stream carrying a program image, assembles little-endian 32-bit words, and issues one single-cycle write per word at incrementing word addresses.
- Holds the CPU in reset while loading and releases it when the image is complete.
- Sits between a byte source (UART receiver or testbench) and the CPU top level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word.
- MAX_WORDS, 1024, maximum accepted word count; larger headers are clamped.
- CNT_W, 16, width of the internal word counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- Ext_MemWrite  output  1  single-cycle write strobe.
- Ext_WriteData  output  32  assembled word.
- Ext_DataAdr  output  32  byte address of the word.
- cpu_reset  output  1  active-high reset driven to the CPU top level.
- done  output  1  image fully written.
- error  output  1  header exceeded MAX_WORDS (sticky until reset).

Behaviour:
- Reset values: Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=BASE_ADDR, cpu_reset=1, done=0, error=0, in_ready=0, state=HDR.
- A byte transfers on the rising edge where in_valid && in_ready.
- in_ready=1 in HDR and DATA; 0 in WRITE and RUN.
- Stream format: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte → bits [7:0]).
- Byte position: 2-bit counter, wraps 3→0.
- State HDR:
  - Collect 4 bytes into the count register.
  - On the 4th byte: if N==0, go to RUN.
  - Otherwise load remaining = min(N, MAX_WORDS), set error=1 if N>MAX_WORDS, and go to DATA.
- State DATA:
  - Shift bytes into the assembly register.
  - On the 4th byte, go to WRITE.
- State WRITE (exactly one cycle):
  - Ext_MemWrite=1; Ext_WriteData and Ext_DataAdr are stable this cycle.
  - Next cycle: Ext_DataAdr += 4 and remaining -= 1.
  - If remaining becomes 0, go to RUN; otherwise go to DATA.
- State RUN (terminal until reset):
  - cpu_reset=0, done=1; all further bytes are ignored (in_ready=0).
- cpu_reset=1 in every state except RUN.
  - This guarantees the top-level gating (write passthrough only while its reset is high) admits every write.
- Latency: Ext_MemWrite asserts the cycle after the 4th byte of a word is accepted.
  - Best-case throughput is one word per 5 cycles.
- Ext_DataAdr wraps modulo 2^32 with no error.
- Bytes beyond MAX_WORDS words after a clamp are not consumed.
  - The source is responsible for draining them; the loader is already in RUN.
- in_valid gaps mid-word are allowed; the partial word and byte counter are held indefinitely.
- reset_n asserted mid-load:
  - Immediately (asynchronously) returns all outputs to reset values, aborts any partial word, and drops Ext_MemWrite.
  - The next load restarts at HDR and BASE_ADDR.
- Ext_WriteData holds its last written value outside WRITE.
- Ext_MemWrite is never asserted outside WRITE.

Decomposition:
- Shared package: state encoding (HDR, DATA, WRITE, RUN as 2-bit localparams) and the byte-stream header length constant HDR_BYTES=4.
  - The future memory-dump reader reuses the same framing.
- One natural sub-module: le_word_asm.
  - 8-to-32 little-endian assembler with a 2-bit position counter, a word_valid pulse, and a clear input.
  - Used by both the HDR and DATA states.
- FSM and address counter stay in prog_loader.

Test Plan:
- Header 01 00 00 00, data EF BE AD DE → one Ext_MemWrite pulse with Ext_WriteData=32'hDEADBEEF, Ext_DataAdr=BASE_ADDR; next cycle cpu_reset=0, done=1.
- N=3, words 0x11111111, 0x22222222, 0x33333333, in_valid held high → writes at 0x0, 0x4, 0x8 spaced 5 cycles apart; exactly 3 strobes; in_ready=0 during each WRITE.
- N=2 with random in_valid gaps of 0–7 cycles, including mid-word → same data and addresses as the gap-free run; no spurious strobes.
- Header N=0 → no Ext_MemWrite; RUN, cpu_reset=0, done=1 the cycle after the 4th header byte.
- MAX_WORDS=2, header N=5 → error=1 sticky, exactly 2 writes, then RUN; extra bytes see in_ready=0.
- reset_n pulsed low after 2 bytes of word 1 (asynchronously, between clock edges) → outputs return to reset values immediately; a fresh image then loads from BASE_ADDR with correct byte alignment.
